// File: rtl/wb_pkg.sv
// Shared constants and extension helpers for the write-back stage.
package wb_pkg;
   localparam logic [1:0] LOAD_BYTE = 2'b00;
   localparam logic [1:0] LOAD_HALF = 2'b01;
   localparam logic [1:0] LOAD_WORD = 2'b10;
   localparam logic [4:0] REG_ZERO  = 5'd0;

   function automatic logic [31:0] extend8(input logic [7:0] v, input logic unsig);
      return unsig ? {24'd0, v} : {{24{v[7]}}, v};
   endfunction

   function automatic logic [31:0] extend16(input logic [15:0] v, input logic unsig);
      return unsig ? {16'd0, v} : {{16{v[15]}}, v};
   endfunction
endpackage

// File: rtl/write_back_load_aligner.sv
// Combinational big-endian sub-word extraction and extension for loads.
module load_aligner
   import wb_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsig_i,
   output logic [31:0] aligned_o,
   output logic        misalign_o
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed field, then extend according to load size.
   always_comb begin
      byte_s     = 8'd0;
      half_s     = 16'd0;
      aligned_o  = data_i;
      misalign_o = 1'b0;
      case (offset_i)
         2'd0:    byte_s = data_i[31:24];
         2'd1:    byte_s = data_i[23:16];
         2'd2:    byte_s = data_i[15:8];
         2'd3:    byte_s = data_i[7:0];
         default: byte_s = 8'd0;
      endcase
      if (offset_i[1]) begin
         half_s = data_i[15:0];
      end else begin
         half_s = data_i[31:16];
      end
      case (size_i)
         LOAD_BYTE: aligned_o = extend8(byte_s, unsig_i);
         LOAD_HALF: begin
            aligned_o  = extend16(half_s, unsig_i);
            misalign_o = offset_i[0];
         end
         default:   aligned_o = data_i;
      endcase
   end
endmodule

// File: rtl/write_back.sv
// WB stage: MEM/WB register, result mux, r0 guard and retired-instruction counter.
// Sub-word load support is compiled in when WB_SUBWORD_LOAD_EN is defined.
module write_back
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic              mem_to_reg,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_load_data,
   input  logic [1:0]        mem_load_size,
   input  logic              mem_load_unsig,
   input  logic              stall,
   input  logic              flush,
   output logic              reg_write,
   output logic [REG_AW-1:0] rw,
   output logic [DATA_W-1:0] busw,
   output logic              misalign_err,
   output logic [CNT_W-1:0]  retired_count
);
   logic [DATA_W-1:0] aligned_s;
   logic              misalign_s;

`ifdef WB_SUBWORD_LOAD_EN
   load_aligner u_aligner (
      .data_i     (mem_load_data),
      .offset_i   (mem_alu_result[1:0]),
      .size_i     (mem_load_size),
      .unsig_i    (mem_load_unsig),
      .aligned_o  (aligned_s),
      .misalign_o (misalign_s)
   );
`else
   logic unused_s;
   assign unused_s   = ^{mem_load_size, mem_load_unsig};
   assign aligned_s  = mem_load_data;
   assign misalign_s = 1'b0;
`endif

   logic              we_d, we_q;
   logic [REG_AW-1:0] rw_d, rw_q;
   logic [DATA_W-1:0] busw_d, busw_q;
   logic              mis_d, mis_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   // Next state: flush clears, stall holds, otherwise capture the MEM stage.
   always_comb begin
      we_d   = we_q;
      rw_d   = rw_q;
      busw_d = busw_q;
      mis_d  = mis_q;
      cnt_d  = cnt_q;
      if (flush) begin
         we_d   = 1'b0;
         rw_d   = {REG_AW{1'b0}};
         busw_d = {DATA_W{1'b0}};
         mis_d  = 1'b0;
      end else if (stall) begin
         we_d   = we_q;
         cnt_d  = cnt_q;
      end else begin
         we_d   = mem_valid & mem_reg_write & (mem_rd != REG_AW'(REG_ZERO));
         rw_d   = mem_rd;
         busw_d = mem_to_reg ? aligned_s : mem_alu_result;
         mis_d  = mem_valid & mem_to_reg & misalign_s;
         cnt_d  = cnt_q + CNT_W'(mem_valid);
      end
   end

   // MEM/WB register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q   <= 1'b0;
         rw_q   <= {REG_AW{1'b0}};
         busw_q <= {DATA_W{1'b0}};
         mis_q  <= 1'b0;
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         we_q   <= we_d;
         rw_q   <= rw_d;
         busw_q <= busw_d;
         mis_q  <= mis_d;
         cnt_q  <= cnt_d;
      end
   end

   assign reg_write     = we_q;
   assign rw            = rw_q;
   assign busw          = busw_q;
   assign misalign_err  = mis_q;
   assign retired_count = cnt_q;
endmodule

// File: tb/tb_write_back.sv
// Randomized self-checking bench for write_back against a behavioural model.
module tb_write_back;
   localparam int CW = 8;

   logic        clk = 1'b0;
   logic        reset, mem_valid, mem_reg_write, mem_to_reg, mem_load_unsig, stall, flush;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result, mem_load_data;
   logic [1:0]  mem_load_size;
   logic        reg_write, misalign_err;
   logic [4:0]  rw;
   logic [31:0] busw;
   logic [CW-1:0] retired_count;

   int errors = 0;
   int checks = 0;

   logic          e_we, e_mis;
   logic [4:0]    e_rw;
   logic [31:0]   e_busw;
   logic [CW-1:0] e_cnt;

   always #5 clk = ~clk;

   write_back #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
      .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
      .mem_load_unsig(mem_load_unsig), .stall(stall), .flush(flush),
      .reg_write(reg_write), .rw(rw), .busw(busw), .misalign_err(misalign_err),
      .retired_count(retired_count)
   );

   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                            input logic [1:0] sz, input logic unsig);
      logic [31:0] v;
      v = d;
`ifdef WB_SUBWORD_LOAD_EN
      if (sz == 2'd0) begin
         v = (d >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
         if (!unsig && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (d >> (off[1] ? 0 : 16)) & 32'h0000_FFFF;
         if (!unsig && v[15]) v = v | 32'hFFFF_0000;
      end
`endif
      return v;
   endfunction

   function automatic logic ref_mis(input logic [1:0] off, input logic [1:0] sz);
`ifdef WB_SUBWORD_LOAD_EN
      return (sz == 2'd1) && off[0];
`else
      return 1'b0;
`endif
   endfunction

   // One clock: the model follows the rules as the DUT samples, outputs settle by negedge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         e_we = 1'b0; e_rw = 5'd0; e_busw = 32'd0; e_mis = 1'b0; e_cnt = '0;
      end else if (flush) begin
         e_we = 1'b0; e_rw = 5'd0; e_busw = 32'd0; e_mis = 1'b0;
      end else if (!stall) begin
         e_we   = mem_valid && mem_reg_write && (mem_rd != 5'd0);
         e_rw   = mem_rd;
         e_busw = mem_to_reg ? ref_load(mem_load_data, mem_alu_result[1:0], mem_load_size, mem_load_unsig)
                             : mem_alu_result;
         e_mis  = mem_valid && mem_to_reg && ref_mis(mem_alu_result[1:0], mem_load_size);
         if (mem_valid) e_cnt = e_cnt + 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic drive_random();
      mem_valid      = $urandom_range(0, 3) != 0;
      mem_reg_write  = $urandom_range(0, 1);
      mem_to_reg     = $urandom_range(0, 1);
      mem_rd         = 5'($urandom_range(0, 31));
      mem_alu_result = $urandom;
      mem_load_data  = $urandom;
      mem_load_size  = 2'($urandom_range(0, 3));
      mem_load_unsig = $urandom_range(0, 1);
   endtask

   task automatic drive_op(input logic to_reg, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] data, input logic [1:0] sz, input logic unsig);
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_to_reg = to_reg; mem_rd = rd;
      mem_alu_result = alu; mem_load_data = data; mem_load_size = sz; mem_load_unsig = unsig;
      stall = 1'b0; flush = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      for (int i = 0; i < 5; i++) begin drive_random(); tick(); end
      reset = 1'b1;
      drive_random(); stall = 1'b1; tick();
      drive_random(); flush = 1'b1; tick();
      checks++;
      if ({reg_write, rw, busw, misalign_err, retired_count} !== {1'b0, 5'd0, 32'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset: got we=%0b rw=%0d busw=%h mis=%0b cnt=%0d required all zero",
                  reg_write, rw, busw, misalign_err, retired_count);
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_alu_write();
      drive_op(1'b0, 5'd8, 32'h1234_5678, 32'hDEAD_BEEF, 2'b10, 1'b0);
      tick();
      checks++;
      if ({reg_write, rw, busw, retired_count} !== {1'b1, 5'd8, 32'h1234_5678, 8'd1}) begin
         errors++;
         $display("FAIL alu_write: got we=%0b rw=%0d busw=%h cnt=%0d required 1 8 12345678 1",
                  reg_write, rw, busw, retired_count);
      end
   endtask

   task automatic test_loads();
      logic [31:0] want [4];
      logic        wmis [4];
      drive_op(1'b1, 5'd3, 32'h0000_0101, 32'h1180_2233, 2'b00, 1'b0); tick();
      want[0] = 32'h1180_2233; wmis[0] = 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
      want[0] = 32'hFFFF_FF80;
`endif
      checks++;
      if ({busw, misalign_err} !== {want[0], wmis[0]}) begin
         errors++; $display("FAIL lb: got busw=%h mis=%0b required %h %0b", busw, misalign_err, want[0], wmis[0]);
      end
      drive_op(1'b1, 5'd3, 32'h0000_0101, 32'h1180_2233, 2'b00, 1'b1); tick();
      want[1] = 32'h1180_2233; wmis[1] = 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
      want[1] = 32'h0000_0080;
`endif
      checks++;
      if ({busw, misalign_err} !== {want[1], wmis[1]}) begin
         errors++; $display("FAIL lbu: got busw=%h mis=%0b required %h %0b", busw, misalign_err, want[1], wmis[1]);
      end
      drive_op(1'b1, 5'd4, 32'h0000_0002, 32'h0000_8001, 2'b01, 1'b0); tick();
      want[2] = 32'h0000_8001; wmis[2] = 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
      want[2] = 32'hFFFF_8001;
`endif
      checks++;
      if ({busw, misalign_err} !== {want[2], wmis[2]}) begin
         errors++; $display("FAIL lh_off2: got busw=%h mis=%0b required %h %0b", busw, misalign_err, want[2], wmis[2]);
      end
      drive_op(1'b1, 5'd4, 32'h0000_0003, 32'h0000_8001, 2'b01, 1'b0); tick();
      want[3] = 32'h0000_8001; wmis[3] = 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
      want[3] = 32'hFFFF_8001; wmis[3] = 1'b1;
`endif
      checks++;
      if ({busw, misalign_err} !== {want[3], wmis[3]}) begin
         errors++; $display("FAIL lh_off3: got busw=%h mis=%0b required %h %0b", busw, misalign_err, want[3], wmis[3]);
      end
      drive_op(1'b0, 5'd4, 32'h0000_0003, 32'h0000_8001, 2'b01, 1'b0); tick();
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL mis_clear: got mis=%0b required 0", misalign_err);
      end
   endtask

   task automatic test_r0_and_flush();
      logic [CW-1:0] cnt_before;
      drive_op(1'b0, 5'd0, 32'hCAFE_0001, 32'd0, 2'b10, 1'b0); tick();
      checks++;
      if ({reg_write, rw, busw} !== {1'b0, 5'd0, 32'hCAFE_0001}) begin
         errors++; $display("FAIL r0_guard: got we=%0b rw=%0d busw=%h required 0 0 cafe0001", reg_write, rw, busw);
      end
      drive_op(1'b0, 5'd9, 32'h0BAD_F00D, 32'd0, 2'b10, 1'b0); tick();
      cnt_before = retired_count;
      drive_op(1'b1, 5'd7, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0);
      stall = 1'b1; flush = 1'b1; tick();
      checks++;
      if ({reg_write, rw, busw, misalign_err, retired_count} !== {1'b0, 5'd0, 32'd0, 1'b0, cnt_before}) begin
         errors++; $display("FAIL stall_flush: got we=%0b rw=%0d busw=%h mis=%0b cnt=%0d required 0 0 0 0 %0d",
                            reg_write, rw, busw, misalign_err, retired_count, cnt_before);
      end
      flush = 1'b0; stall = 1'b0;
   endtask

   task automatic test_stall_hold();
      drive_op(1'b0, 5'd21, 32'h5555_AAAA, 32'd0, 2'b10, 1'b0); tick();
      for (int i = 0; i < 3; i++) begin
         drive_random(); stall = 1'b1; tick();
         checks++;
         if ({reg_write, rw, busw, misalign_err, retired_count} !== {1'b1, 5'd21, 32'h5555_AAAA, 1'b0, e_cnt}
             || e_busw !== 32'h5555_AAAA) begin
            errors++; $display("FAIL stall_hold: got we=%0b rw=%0d busw=%h cnt=%0d required 1 21 5555aaaa %0d",
                               reg_write, rw, busw, retired_count, e_cnt);
         end
      end
      stall = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_random();
         stall = $urandom_range(0, 5) == 0;
         flush = $urandom_range(0, 7) == 0;
         reset = $urandom_range(0, 60) == 0;
         tick();
         checks++;
         if ({reg_write, rw, busw, misalign_err, retired_count} !== {e_we, e_rw, e_busw, e_mis, e_cnt}) begin
            errors++; $display("FAIL random[%0d]: got we=%0b rw=%0d busw=%h mis=%0b cnt=%0d required %0b %0d %h %0b %0d",
                               i, reg_write, rw, busw, misalign_err, retired_count, e_we, e_rw, e_busw, e_mis, e_cnt);
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_wrap();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < (1 << CW); i++) begin
         drive_random(); mem_valid = 1'b1; tick();
      end
      checks++;
      if (retired_count !== '0) begin
         errors++; $display("FAIL wrap: got cnt=%0d required 0", retired_count);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive_random();
      e_we = 1'b0; e_rw = 5'd0; e_busw = 32'd0; e_mis = 1'b0; e_cnt = '0;
      @(negedge clk);
      test_reset();
      test_alu_write();
      test_loads();
      test_r0_and_flush();
      test_stall_hold();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
